// File: rtl/apbuart_pkg.sv
// Shared definitions for the UART APB completer: CSR offsets, bit positions
// and the APB phase FSM encoding.
package apbuart_pkg;

  localparam logic [7:0] TXDATA_OFS = 8'h00;
  localparam logic [7:0] RXDATA_OFS = 8'h04;
  localparam logic [7:0] STATUS_OFS = 8'h08;
  localparam logic [7:0] CTRL_OFS   = 8'h0C;
  localparam logic [7:0] BAUD_OFS   = 8'h10;

  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_PARITY_EN  = 1;
  localparam int CTRL_PARITY_ODD = 2;
  localparam int CTRL_TWO_STOP   = 3;

  localparam int STAT_TX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_OVERRUN  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apbuart_apb_fsm.sv
// APB3 phase tracker with programmable wait states; emits a one-cycle
// completion strobe and the request fields captured during the setup phase.
module apbuart_apb_fsm
  import apbuart_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic        ready,
  output logic        complete,
  output logic        lat_write,
  output logic [31:0] lat_addr,
  output logic [31:0] lat_wdata
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  apb_state_e state;
  apb_state_e state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic [3:0] cnt_eff;
  logic       setup_seen;
  logic       in_access;

  // The first access cycle is taken while still in SETUP so that zero wait
  // states complete immediately; cnt_eff is the access-cycle index.
  always_comb begin
    setup_seen = psel & ~penable;
    in_access  = psel & penable & ((state == SETUP) | (state == ACCESS));
    cnt_eff    = (state == ACCESS) ? cnt : 4'd0;
    ready      = in_access & (cnt_eff == WAIT_CNT);
    state_nx   = state;
    cnt_nx     = cnt;
    case (state)
      IDLE: begin
        cnt_nx = 4'd0;
        if (setup_seen) begin
          state_nx = SETUP;
        end else begin
          state_nx = IDLE;
        end
      end
      SETUP, ACCESS: begin
        if (!psel) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else if (setup_seen) begin
          state_nx = SETUP;
          cnt_nx   = 4'd0;
        end else if (ready) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else begin
          state_nx = ACCESS;
          cnt_nx   = cnt_eff + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  assign complete = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (setup_seen) begin
      lat_write <= pwrite;
      lat_addr  <= paddr;
      lat_wdata <= pwdata;
    end
  end

endmodule

// File: rtl/apbuart_apb_slave.sv
// APB3 completer for the UART: wait-state FSM plus the CSR bank
// (CTRL, BAUD_DIV, STATUS, TX and RX holding registers).
module apbuart_apb_slave
  import apbuart_pkg::*;
#(
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] BAUD_RST    = 16'd163,
  parameter int          DEC_BITS    = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [3:0]  ctrl,
  output logic [15:0] baud_div
);

  logic                complete;
  logic                lat_write;
  logic [31:0]         lat_addr;
  logic [31:0]         lat_wdata;
  logic [DEC_BITS-1:0] offs;
  logic                aligned;
  logic [31:0]         rd_data;
  logic                err;
  logic                tx_load;
  logic                rx_take;
  logic                ov_clr;
  logic                ctrl_wr;
  logic                baud_wr;
  logic                rd_rx;
  logic                rx_full;
  logic                overrun;
  logic [7:0]          rx_buf;
  logic                unused;

  apbuart_apb_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .psel     (PSELx),
    .penable  (PENABLE),
    .pwrite   (PWRITE),
    .paddr    (PADDR),
    .pwdata   (PWDATA),
    .ready    (PREADY),
    .complete (complete),
    .lat_write(lat_write),
    .lat_addr (lat_addr),
    .lat_wdata(lat_wdata)
  );

  assign offs    = lat_addr[DEC_BITS-1:0];
  assign aligned = (lat_addr[1:0] == 2'b00);
  assign unused  = ^{lat_addr, lat_wdata};

  // Address decode of the latched request; strobes are qualified by complete later.
  always_comb begin
    rd_data = 32'd0;
    err     = 1'b0;
    tx_load = 1'b0;
    rx_take = 1'b0;
    ov_clr  = 1'b0;
    ctrl_wr = 1'b0;
    baud_wr = 1'b0;
    if (!aligned) begin
      err = 1'b1;
    end else begin
      case (offs)
        DEC_BITS'(TXDATA_OFS): begin
          if (lat_write) begin
            if (tx_valid) begin
              err = 1'b1;
            end else begin
              tx_load = 1'b1;
            end
          end else begin
            rd_data = 32'd0;
          end
        end
        DEC_BITS'(RXDATA_OFS): begin
          if (lat_write || !rx_full) begin
            err = 1'b1;
          end else begin
            rd_data = {24'd0, rx_buf};
            rx_take = 1'b1;
          end
        end
        DEC_BITS'(STATUS_OFS): begin
          if (lat_write) begin
            ov_clr = lat_wdata[STAT_OVERRUN];
          end else begin
            rd_data[STAT_TX_VALID] = tx_valid;
            rd_data[STAT_RX_FULL]  = rx_full;
            rd_data[STAT_OVERRUN]  = overrun;
          end
        end
        DEC_BITS'(CTRL_OFS): begin
          if (lat_write) begin
            ctrl_wr = 1'b1;
          end else begin
            rd_data[CTRL_TWO_STOP:CTRL_ENABLE] = ctrl;
          end
        end
        DEC_BITS'(BAUD_OFS): begin
          if (lat_write) begin
            if (lat_wdata[15:0] == 16'd0) begin
              err = 1'b1;
            end else begin
              baud_wr = 1'b1;
            end
          end else begin
            rd_data[15:0] = baud_div;
          end
        end
        default: err = 1'b1;
      endcase
    end
  end

  assign PRDATA  = (complete && !lat_write) ? rd_data : 32'd0;
  assign PSLVERR = complete & err;
  assign rd_rx   = complete & rx_take;

  // TX holding register: loaded by the bus, drained by the engine handshake.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
    end else if (complete && tx_load) begin
      tx_valid <= 1'b1;
      tx_data  <= lat_wdata[7:0];
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  // A completing RXDATA read frees the buffer in time for a same-cycle byte.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_full <= 1'b0;
      rx_buf  <= 8'd0;
      overrun <= 1'b0;
    end else begin
      if (rx_valid && (!rx_full || rd_rx)) begin
        rx_buf  <= rx_data;
        rx_full <= 1'b1;
      end else if (rd_rx) begin
        rx_full <= 1'b0;
      end
      overrun <= (rx_valid && rx_full && !rd_rx) || (overrun && !(complete && ov_clr));
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl     <= 4'd0;
      baud_div <= BAUD_RST;
    end else begin
      if (complete && ctrl_wr) begin
        ctrl <= {lat_wdata[CTRL_TWO_STOP], lat_wdata[CTRL_PARITY_ODD],
                 lat_wdata[CTRL_PARITY_EN], lat_wdata[CTRL_ENABLE]};
      end
      if (complete && baud_wr) begin
        baud_div <= lat_wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_apbuart_apb_slave.sv
// Self-checking bench for apbuart_apb_slave: directed scenarios plus random
// APB traffic, checked every cycle against a register-level model.
module tb_apbuart_apb_slave;

  localparam int          WAIT     = 1;
  localparam logic [15:0] BAUD_RST = 16'd163;
  localparam int PH_IDLE = 0, PH_SETUP = 1, PH_ACC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = 32'd0, pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [3:0]  ctrl;
  logic [15:0] baud_div;

  apbuart_apb_slave #(.WAIT_STATES(WAIT), .BAUD_RST(BAUD_RST), .DEC_BITS(8)) dut (
    .PCLK(clk), .PRESETn(rst_n), .PSELx(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .ctrl(ctrl), .baud_div(baud_div)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int phase = PH_IDLE;
  int acc = 0;
  bit chk_en = 1'b0, rand_engine = 1'b0, inject_rx = 1'b0;
  logic [7:0] inject_data = 8'd0;

  // Register-level model state
  logic       m_tv, m_rf, m_ov;
  logic [7:0] m_txd, m_rxb;
  logic [3:0] m_ctrl;
  logic [15:0] m_baud;

  // {error, read data} the register map prescribes for a request, given model state.
  function automatic logic [32:0] model_resp(input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (a[1:0] != 2'b00) return {1'b1, 32'd0};
    case (a[7:0])
      8'h00: return wr ? {m_tv, 32'd0} : 33'd0;
      8'h04: if (wr || !m_rf) return {1'b1, 32'd0}; else return {1'b0, 24'd0, m_rxb};
      8'h08: return wr ? 33'd0 : {1'b0, 29'd0, m_ov, m_rf, m_tv};
      8'h0C: return wr ? 33'd0 : {1'b0, 28'd0, m_ctrl};
      8'h10: return wr ? {(d[15:0] == 16'd0), 32'd0} : {1'b0, 16'd0, m_baud};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Model update: bus side effect first, then engine events (so hardware set wins).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tv <= 1'b0; m_rf <= 1'b0; m_ov <= 1'b0;
      m_txd <= 8'd0; m_rxb <= 8'd0; m_ctrl <= 4'd0; m_baud <= BAUD_RST;
    end else begin : upd
      logic tv, rf, ov, hs, done;
      logic [7:0] txd, rxb;
      logic [3:0] ct;
      logic [15:0] bd;
      logic [32:0] r;
      tv = m_tv; rf = m_rf; ov = m_ov; txd = m_txd; rxb = m_rxb; ct = m_ctrl; bd = m_baud;
      done = (phase == PH_ACC) && (acc == WAIT);
      hs = m_tv && tx_ready;
      r = model_resp(pwrite, paddr, pwdata);
      if (done && !r[32]) begin
        if (pwrite) begin
          case (paddr[7:0])
            8'h00: begin tv = 1'b1; txd = pwdata[7:0]; end
            8'h08: if (pwdata[2]) ov = 1'b0;
            8'h0C: ct = pwdata[3:0];
            8'h10: bd = pwdata[15:0];
            default: ;
          endcase
        end else if (paddr[7:0] == 8'h04) begin
          rf = 1'b0;
        end
      end
      if (hs) tv = 1'b0;
      if (rx_valid) begin
        if (rf) ov = 1'b1;
        else begin rf = 1'b1; rxb = rx_data; end
      end
      m_tv <= tv; m_rf <= rf; m_ov <= ov; m_txd <= txd; m_rxb <= rxb; m_ctrl <= ct; m_baud <= bd;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [32:0] r;
    bit c;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        c = (phase == PH_ACC) && (acc == WAIT);
        r = model_resp(pwrite, paddr, pwdata);
        check("pready", {31'd0, pready}, {31'd0, c});
        check("pslverr", {31'd0, pslverr}, {31'd0, c & r[32]});
        check("prdata", prdata, (c && !pwrite) ? r[31:0] : 32'd0);
        check("tx_valid", {31'd0, tx_valid}, {31'd0, m_tv});
        check("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
        check("ctrl", {28'd0, ctrl}, {28'd0, m_ctrl});
        check("baud_div", {16'd0, baud_div}, {16'd0, m_baud});
      end
    end
  endtask

  task automatic engine_tick(input bit completing);
    if (inject_rx && completing) begin
      rx_valid = 1'b1; rx_data = inject_data;
    end else if (rand_engine) begin
      rx_valid = ($urandom_range(4) == 0);
      rx_data  = 8'($urandom);
      tx_ready = ($urandom_range(2) == 0);
    end else begin
      rx_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      psel = 1'b0; penable = 1'b0; phase = PH_IDLE; acc = 0;
      engine_tick(1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input bit abort,
                          output logic [31:0] rd, output logic err, output int ncyc);
    bit done;
    done = 1'b0; rd = 32'd0; err = 1'b0; ncyc = 0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; phase = PH_SETUP; acc = 0;
    engine_tick(1'b0);
    @(posedge clk); #1;
    penable = 1'b1; phase = PH_ACC;
    for (int k = 0; k < 40 && !done; k++) begin
      engine_tick(acc == WAIT);
      @(negedge clk);
      if (pready === 1'b1) begin rd = prdata; err = pslverr; done = 1'b1; end
      @(posedge clk); #1;
      ncyc++;
      if (!done) begin
        acc++;
        if (abort) break;
      end
    end
    if (abort && !done) begin
      psel = 1'b0; penable = 1'b0; phase = PH_IDLE; acc = 0;
      engine_tick(1'b0);
      @(posedge clk); #1;
    end else if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no PREADY for addr %0h, got none expected completion", a);
    end
    psel = 1'b0; penable = 1'b0; phase = PH_IDLE; acc = 0;
    engine_tick(1'b0);
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic err;
    int nc;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_baud", {16'd0, baud_div}, 32'h0000_00A3);
    check("rst_ctrl", {28'd0, ctrl}, 32'd0);

    // Scenario 1: reset-value reads, latency
    apb_xfer(1'b0, 32'h10, 32'd0, 1'b0, rd, err, nc);
    check("t1_baud_rd", rd, 32'h0000_00A3);
    check("t1_baud_err", {31'd0, err}, 32'd0);
    check("t1_latency", nc, 32'd2);
    apb_xfer(1'b0, 32'h08, 32'd0, 1'b0, rd, err, nc);
    check("t1_status_rd", rd, 32'd0);

    // Scenario 2: TX holding register
    apb_xfer(1'b1, 32'h00, 32'h41, 1'b0, rd, err, nc);
    check("t2_wr1_err", {31'd0, err}, 32'd0);
    check("t2_tx_valid", {31'd0, tx_valid}, 32'd1);
    check("t2_tx_data", {24'd0, tx_data}, 32'h41);
    apb_xfer(1'b1, 32'h00, 32'h42, 1'b0, rd, err, nc);
    check("t2_wr2_err", {31'd0, err}, 32'd1);
    check("t2_tx_data_kept", {24'd0, tx_data}, 32'h41);
    tx_ready = 1'b1; @(posedge clk); #1 tx_ready = 1'b0;
    check("t2_tx_drained", {31'd0, tx_valid}, 32'd0);

    // Scenario 3: overrun and W1C
    pulse_rx(8'h55);
    pulse_rx(8'h66);
    apb_xfer(1'b0, 32'h08, 32'd0, 1'b0, rd, err, nc);
    check("t3_status", rd, 32'h6);
    apb_xfer(1'b0, 32'h04, 32'd0, 1'b0, rd, err, nc);
    check("t3_rxdata", rd, 32'h55);
    apb_xfer(1'b1, 32'h08, 32'h4, 1'b0, rd, err, nc);
    apb_xfer(1'b0, 32'h08, 32'd0, 1'b0, rd, err, nc);
    check("t3_status_clr", rd, 32'h0);

    // Scenario 4: RX byte arriving on the completing read
    pulse_rx(8'h55);
    inject_rx = 1'b1; inject_data = 8'h77;
    apb_xfer(1'b0, 32'h04, 32'd0, 1'b0, rd, err, nc);
    inject_rx = 1'b0;
    check("t4_old_byte", rd, 32'h55);
    apb_xfer(1'b0, 32'h08, 32'd0, 1'b0, rd, err, nc);
    check("t4_status", rd, 32'h2);
    apb_xfer(1'b0, 32'h04, 32'd0, 1'b0, rd, err, nc);
    check("t4_new_byte", rd, 32'h77);

    // Scenario 5: error responses
    apb_xfer(1'b0, 32'h14, 32'd0, 1'b0, rd, err, nc);
    check("t5_bad_ofs", {31'd0, err}, 32'd1);
    apb_xfer(1'b0, 32'h02, 32'd0, 1'b0, rd, err, nc);
    check("t5_unaligned", {31'd0, err}, 32'd1);
    apb_xfer(1'b1, 32'h10, 32'd0, 1'b0, rd, err, nc);
    check("t5_baud_zero", {31'd0, err}, 32'd1);
    check("t5_baud_kept", {16'd0, baud_div}, 32'hA3);
    apb_xfer(1'b0, 32'h04, 32'd0, 1'b0, rd, err, nc);
    check("t5_rx_empty_err", {31'd0, err}, 32'd1);
    check("t5_rx_empty_data", rd, 32'd0);
    apb_xfer(1'b1, 32'h0C, 32'hFFFF_FFF5, 1'b0, rd, err, nc);
    apb_xfer(1'b0, 32'h0C, 32'd0, 1'b0, rd, err, nc);
    check("t5_ctrl_rd", rd, 32'h5);
    apb_xfer(1'b1, 32'hABCD_0010, 32'h0000_1234, 1'b0, rd, err, nc);
    check("t5_baud_upper_ignored", {16'd0, baud_div}, 32'h1234);

    // Scenario 6: reset in the middle of an access wait
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hF; phase = PH_SETUP; acc = 0;
    @(posedge clk); #1;
    penable = 1'b1; phase = PH_ACC;
    @(negedge clk); #2;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; phase = PH_IDLE;
    #1;
    check("t6_ctrl_rst", {28'd0, ctrl}, 32'd0);
    check("t6_pready_rst", {31'd0, pready}, 32'd0);
    check("t6_baud_rst", {16'd0, baud_div}, 32'hA3);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);
    apb_xfer(1'b1, 32'h0C, 32'hF, 1'b0, rd, err, nc);
    check("t6_ctrl_after", {28'd0, ctrl}, 32'hF);

    // Random traffic with random engine activity and occasional aborts
    rand_engine = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(6))
        0: a = 32'h00;
        1: a = 32'h04;
        2: a = 32'h08;
        3: a = 32'h0C;
        4: a = 32'h10;
        default: a = 32'($urandom_range(255));
      endcase
      a = a | ($urandom & 32'hFFFF_FF00);
      d = $urandom;
      if ($urandom_range(4) == 0) d[15:0] = 16'd0;
      apb_xfer(1'($urandom_range(1)), a, d, ($urandom_range(19) == 0), rd, err, nc);
      if ($urandom_range(1) == 1) idle($urandom_range(2));
    end
    rand_engine = 1'b0;
    idle(3);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apbuart_apb_slave.md
Name: apbuart_apb_slave

Overview:
APB3 completer that fronts the UART core. It decodes APB transfers from the bus, inserts programmable wait states, and owns the UART CSR bank. The bank holds CTRL, BAUD_DIV, STATUS, a one-byte TX holding register and a one-byte RX holding register. It sits between the APB fabric and the UART TX/RX engines, and is the DUT-side counterpart of the bench's APB driver.

Parameters:
WAIT_STATES, 1, number of access-phase cycles with PREADY low before completion (0..15)
BAUD_RST, 16'd163, reset value of BAUD_DIV
DEC_BITS, 8, PADDR LSBs used for decode; upper bits ignored

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  async active-low reset
PSELx  in  1  slave select
PENABLE  in  1  access phase
PWRITE  in  1  1=write
PADDR  in  32  byte address
PWDATA  in  32  write data
PRDATA  out  32  read data, valid only on completion cycle
PREADY  out  1  transfer completion
PSLVERR  out  1  error, valid only on completion cycle
tx_data  out  8  byte to UART TX engine
tx_valid  out  1  TX holding register full
tx_ready  in  1  TX engine accepts byte
rx_data  in  8  byte from UART RX engine
rx_valid  in  1  one-cycle strobe: new RX byte
ctrl  out  4  CTRL[3:0]: enable, parity_en, parity_odd, two_stop
baud_div  out  16  baud divisor

Behaviour:
- Interface: one clock PCLK. Reset PRESETn is asynchronous and active-low.
- Reset values:
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - tx_valid=0, tx_data=0, ctrl=0, baud_div=BAUD_RST.
  - rx_full=0, overrun=0, FSM=IDLE, wait counter=0.
- FSM states and transitions:
  - IDLE: on PSELx=1 & PENABLE=0 (setup) -> SETUP.
  - SETUP: PENABLE=1 -> ACCESS with cnt=0. PSELx=0 -> IDLE.
  - ACCESS: PREADY = (cnt==WAIT_STATES), combinational from state/cnt. cnt increments while PREADY=0.
  - Completion cycle (PREADY=1): goes to SETUP if PSELx=1 & PENABLE=0 is sampled next, else IDLE.
- Latency: WAIT_STATES=N gives an access phase of N+1 cycles. N=0 completes in the first access cycle.
- PSELx deasserted during ACCESS is a protocol violation: -> IDLE, no side effects, PREADY stays 0.
- Address latch: PADDR, PWRITE and PWDATA are captured in SETUP and used at completion.
- Side effects happen only on the completion cycle, at that clock edge.
- PRDATA and PSLVERR are 0 on every non-completion cycle.
- Register map (offset within DEC_BITS):
  - 0x00 TXDATA, W:
    - tx_valid=0: load tx_data=PWDATA[7:0], set tx_valid.
    - tx_valid=1: PSLVERR=1, data dropped. This holds even if tx_ready=1 in the same cycle.
    - Read returns 0.
  - 0x04 RXDATA, R:
    - rx_full=1: PRDATA={24'b0,rx_buf}, clear rx_full.
    - rx_full=0: PRDATA=0, PSLVERR=1.
    - Write gives PSLVERR=1.
  - 0x08 STATUS:
    - R: {29'b0, overrun, rx_full, tx_valid}.
    - W: PWDATA[2]=1 clears overrun (W1C). Other bits ignored.
  - 0x0C CTRL: RW, bits [3:0]. Upper bits read 0.
  - 0x10 BAUD_DIV: RW, bits [15:0].
    - Write of 0 gives PSLVERR=1 and leaves the value unchanged.
  - Any other offset, or PADDR[1:0]!=0: PSLVERR=1, no side effect, PRDATA=0.
- TX handshake: tx_valid & tx_ready at an edge clears tx_valid. tx_data holds until then.
- RX:
  - rx_valid with rx_full=0: load rx_buf, set rx_full.
  - rx_valid with rx_full=1: set overrun (sticky), keep old rx_buf.
  - rx_valid in the same cycle as a completing RXDATA read: read returns the old byte, new byte is loaded, rx_full stays 1, no overrun.
- Overrun set by hardware and W1C in the same cycle: set wins.
- PRESETn asserted mid-transfer: immediate return to reset values. The bus master must restart the transfer.

Decomposition:
- Package apbuart_pkg:
  - Register offset localparams (TXDATA_OFS..BAUD_OFS).
  - CTRL bit indices.
  - STATUS bit indices.
  - FSM state enum apb_state_e {IDLE, SETUP, ACCESS}.
- Sub-module apbuart_apb_fsm:
  - Contains the phase FSM and wait counter.
  - Outputs a one-cycle `complete` strobe plus latched addr/write/wdata.
- The CSR bank and decode stay in the top level.

Test Plan:
1. Reset, then read 0x10 and 0x08 with WAIT_STATES=1 -> PRDATA=0x000000A3 then 0x0; PREADY high exactly on the 2nd access cycle; PSLVERR=0.
2. Write 0x41 to 0x00 with tx_ready=0, write 0x42 to 0x00 again -> first OKAY with tx_valid=1 and tx_data=0x41; second PSLVERR=1, tx_data still 0x41; pulse tx_ready -> tx_valid=0.
3. Pulse rx_valid with 0x55, then rx_valid with 0x66, read 0x08 -> 0x6 (overrun & rx_full); read 0x04 -> 0x55; write 0x4 to 0x08 -> STATUS reads 0x0.
4. Read 0x04 while rx_valid=0x77 fires on the completion cycle with rx_full=1 (old 0x55) -> PRDATA=0x55, rx_full stays 1, overrun=0; next read returns 0x77.
5. Access 0x14, 0x02 and write 0 to 0x10 -> PSLVERR=1 each; baud_div unchanged; read 0x04 when empty -> PSLVERR=1, PRDATA=0.
6. Assert PRESETn low during the ACCESS wait of a CTRL write of 0xF -> ctrl=0, PREADY=0, FSM IDLE; a subsequent clean write of 0xF to 0x0C -> ctrl=4'hF.
